// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the pipeline stage registers: default widths, the NOP
// bubble instruction, the reset PC and the stage occupancy state encoding.
package pipe_stage_skid_pkg;

  localparam int unsigned PcWDefault   = 32;
  localparam int unsigned InstWDefault = 32;

  localparam logic [31:0] NopInst        = 32'h0000_0013;
  localparam logic [31:0] ResetPcDefault = 32'h8000_0000;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_payload_reg.sv
// Enable register with synchronous active-low reset to a parametrised value;
// holds one concatenated {pc, inst, data} stage payload.
module pipe_payload_reg #(
  parameter int unsigned W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage register with optional two-entry skid buffer,
// flush-to-bubble, occupancy report and saturating stall-cycle counter.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int unsigned     PC_W     = PcWDefault,
  parameter int unsigned     INST_W   = InstWDefault,
  parameter int unsigned     DATA_W   = 64,
  parameter bit              SKID     = 1'b1,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(ResetPcDefault),
  parameter int unsigned     CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int unsigned PayW = PC_W + INST_W + DATA_W;
  localparam logic [PayW-1:0] BubblePay = {RESET_PC, INST_W'(NopInst), {DATA_W{1'b0}}};

  state_e          state_q, state_d;
  logic            in_fire, out_fire;
  logic            main_en, skid_en, main_from_skid, load_bubble;
  logic [PayW-1:0] in_pay, main_d, main_q, skid_q;
  logic [CNT_W-1:0] stall_q;

  assign in_pay    = {in_pc, in_inst, in_data};
  assign in_fire   = in_valid & in_ready;
  assign out_valid = (state_q != StEmpty);
  assign out_fire  = out_valid & out_ready;
  assign occupancy = state_q;
  assign {out_pc, out_inst, out_data} = main_q;
  assign stall_cnt = stall_q;

  // Flush wins over both handshakes; an out_fire in that cycle still counts downstream.
  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    load_bubble    = 1'b0;
    if (flush) begin
      state_d     = StEmpty;
      main_en     = 1'b1;
      load_bubble = 1'b1;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_fire) begin
            state_d = StOne;
            main_en = 1'b1;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            main_en = 1'b1;
          end else if (in_fire) begin
            state_d = StTwo;
            skid_en = 1'b1;
          end else if (out_fire) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          if (out_fire) begin
            state_d        = StOne;
            main_en        = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_comb begin
    main_d = in_pay;
    if (load_bubble) begin
      main_d = BubblePay;
    end else if (main_from_skid) begin
      main_d = skid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  pipe_payload_reg #(
    .W       (PayW),
    .RST_VAL (BubblePay)
  ) u_main (
    .clk (clk),
    .rst (rst),
    .en  (main_en),
    .d   (main_d),
    .q   (main_q)
  );

  if (SKID) begin : g_skid
    logic in_ready_q;

    pipe_payload_reg #(
      .W       (PayW),
      .RST_VAL (BubblePay)
    ) u_skid (
      .clk (clk),
      .rst (rst),
      .en  (skid_en),
      .d   (in_pay),
      .q   (skid_q)
    );

    always_ff @(posedge clk) begin
      if (!rst) begin
        in_ready_q <= 1'b1;
      end else begin
        in_ready_q <= (state_d != StTwo);
      end
    end

    assign in_ready = in_ready_q;
  end else begin : g_no_skid
    assign skid_q   = '0;
    assign in_ready = ~out_valid | out_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the plain IF/ID and ID/EX stage registers.
- One pipeline stage register carrying PC, instruction and an extra payload, with valid/ready handshake, optional 2-entry skid buffer, flush-to-bubble, occupancy and stall-cycle counter.
- Sits between any two CPU stages (IFU->IDU, IDU->EXU, EXU->LSU), so back-pressure and branch flush propagate without combinational ready chains.

Parameters:
- PC_W, 32, PC field width.
- INST_W, 32, instruction field width.
- DATA_W, 64, extra payload width (op1/op2, rd, control bits); minimum 1.
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- RESET_PC, 32'h80000000, out_pc value after reset.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- flush  in  1  discard stage contents and insert a bubble.
- in_valid  in  1  upstream holds valid data.
- in_ready  out  1  stage accepts data this cycle.
- in_pc  in  PC_W  upstream PC.
- in_inst  in  INST_W  upstream instruction.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  stage holds valid data.
- out_ready  in  1  downstream accepts.
- out_pc  out  PC_W  PC of head entry.
- out_inst  out  INST_W  instruction of head entry.
- out_data  out  DATA_W  payload of head entry.
- occupancy  out  2  entries held (0..2).
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Reset (rst=0 sampled on clk edge): state EMPTY, out_valid=0, out_pc=RESET_PC, out_inst=NOP (32'h00000013, zero-extended/truncated to INST_W), out_data=0, occupancy=0, stall_cnt=0, in_ready=1 (SKID=1). Inputs are ignored while rst=0. Reset mid-transfer drops both entries.
- Fire: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Outputs come only from the MAIN register. No combinational path from in_* to out_*. Latency is 1 cycle from in_fire to out_valid.
- States for SKID=1: EMPTY, ONE (MAIN full), TWO (MAIN+SKID full). in_ready = (state != TWO), registered.
  - EMPTY: in_fire -> ONE, MAIN<=in.
  - ONE:
    - in_fire & out_fire -> ONE, MAIN<=in.
    - in_fire & !out_fire -> TWO, SKID<=in.
    - !in_fire & out_fire -> EMPTY.
    - Otherwise hold.
  - TWO: out_fire -> ONE, MAIN<=SKID. Otherwise hold.
- SKID=0: states EMPTY/ONE only; in_ready = !out_valid | out_ready (combinational). The SKID register is not generated.
- Flush is highest priority over in_fire and out_fire:
  - Next state EMPTY; out_valid=0 next cycle.
  - MAIN loaded with bubble: out_pc=RESET_PC, out_inst=NOP, out_data=0. SKID contents are invalidated.
  - An input handshaking in the flush cycle is dropped.
  - An out_fire in the flush cycle is still a valid transfer downstream.
- Held data: while out_valid=1 and !out_ready, out_* stays stable. Payload registers are written only on load, never on idle cycles.
- occupancy = encoding of state (EMPTY=0, ONE=1, TWO=2).
- stall_cnt: increments by 1 each cycle with out_valid & !out_ready and stops at all-ones. Flush does not clear it; only reset does.

Decomposition:
- Shared package (extend the existing define file):
  - PC_W/INST_W defaults.
  - NOP instruction constant 32'h00000013.
  - RESET_PC.
  - State encoding (EMPTY=2'd0, ONE=2'd1, TWO=2'd2).
- One sub-module, pipe_payload_reg:
  - Width-parametrised enable register with synchronous active-low reset and parametrised reset value.
  - Instantiated for MAIN and, under generate SKID=1, for SKID.
  - Concatenated {pc, inst, data} payload.

Test Plan:
- Reset, then in_valid=1, in_pc=32'h80000000, in_inst=32'h00100093, out_ready=1 -> next cycle out_valid=1, out_pc=32'h80000000, out_inst=32'h00100093, occupancy=1; reset values checked before that.
- Back-pressure: out_ready=0, push PCs 32'h80000004 then 32'h80000008 -> occupancy=2, in_ready=0 next cycle, out_pc holds 32'h80000004. Release out_ready -> outputs 0x..04 then 0x..08 in order, no loss or duplication.
- Streaming: out_ready=1, in_valid=1 for 100 cycles with incrementing PC -> 100 outputs in order, in_ready never drops, stall_cnt=0.
- Flush at occupancy=2 with simultaneous in_valid=1 -> next cycle out_valid=0, out_inst=32'h00000013, out_pc=RESET_PC, occupancy=0; flushed input never appears.
- Stall counter: CNT_W=4, out_ready=0 with data held for 20 cycles -> stall_cnt=15 (saturated); reset -> 0.
- SKID=0 build: out_ready=0 with one entry -> in_ready=0 in the same cycle; out_ready=1 -> in_ready=1 in the same cycle, throughput 1/cycle.
